mxrstseq: RTL and testbench
===========================

# mxrstseq

Parametrised multi-channel reset sequencer that generalises the board clock/reset block's single debounced system reset and fixed NOR-flash early release. It gates on a synchronised PLL lock, stretches reset, then releases N reset domains in ascending order with per-channel programmable delays. Optionally it monitors lock loss at run time. It sits beside the PLL/BUFG clock tree and drives `sys_rst` plus the early-release resets for peripherals such as flash and the DDR PHY.

## Interface
- `N_CHAN`, 4, number of sequenced reset channels (1..16)
- `DLY_W`, 8, width of each per-channel delay field
- `CHAN_DLY`, {8'd255, 8'd128, 8'd16, 8'd0}, packed `N_CHAN*DLY_W`; channel i delay = `CHAN_DLY[i*DLY_W +: DLY_W]`
- `STRETCH_W`, 20, stretch counter width
- `STRETCH_CYC`, 20'hFFFFF, cycles of reset stretch after lock is seen (minus one, see Timing)
- `sys_clk`  in  1  sole clock
- `sys_rst_n`  in  1  asynchronous, active-low reset
- `pll_locked`  in  1  PLL lock, asynchronous; 2-flop synchroniser inside (`lock_s`)
- `trigger_reset`  in  1  synchronous re-sequence request, level
- `chan_rst_n`  out  N_CHAN  per-channel active-low resets, bit 0 released first
- `sys_rst`  out  1  active-high, asserted until the last channel is released
- `ready`  out  1  high in RUN
- `lock_lost`  out  1  sticky lock-loss flag (0 when monitor compiled out)

## Operation
- States: WAIT_LOCK, STRETCH, SEQ, RUN. Internal registers: `cnt` (STRETCH_W bits), `dly` (DLY_W bits), `idx` (clog2(N_CHAN), min 1 bit).
- WAIT_LOCK: all `chan_rst_n`=0. If `lock_s`=1, load `cnt`<=STRETCH_CYC and go to STRETCH.
- STRETCH: if `cnt`==0, go to SEQ with `idx`<=0 and `dly`<=CHAN_DLY[0]. Otherwise decrement `cnt`.
- SEQ: if `dly`==0, set `chan_rst_n[idx]`<=1.
  - If `idx`==N_CHAN-1, go to RUN and set `ready`<=1, `sys_rst`<=0 on the same edge.
  - Otherwise increment `idx` and load the next channel's delay.
  - If `dly`!=0, decrement `dly`.
- RUN: hold. Released channels stay released.
- `trigger_reset`=1 has top priority in every state:
  - `chan_rst_n`<=0, `sys_rst`<=1, `ready`<=0, `lock_lost`<=0, state<=WAIT_LOCK.
  - While held, the block stays in WAIT_LOCK.
- Delay 0 means the channel releases on the first SEQ edge after the previous channel's release.
- Counters never wrap. The zero test precedes the decrement.

## Timing
- Async reset (`sys_rst_n`=0), outputs: `chan_rst_n`=0, `sys_rst`=1, `ready`=0, `lock_lost`=0, state=WAIT_LOCK. Synchroniser flops clear to 0.
- The reset release is consumed synchronously; the first active edge evaluates WAIT_LOCK.
- If `pll_locked` rises before edge A, `lock_s`=1 at edge A+1 and the FSM enters STRETCH at edge A+2.
- STRETCH occupies STRETCH_CYC+1 edges.
- Channel i releases d_i+1 edges after channel i-1. Channel 0 counts from the edge that entered SEQ.
- All outputs are registered, with no combinational path from inputs.
- If `trigger_reset` and lock loss occur on the same edge, the trigger wins and `lock_lost` stays 0.

## Configuration
- `MXRSTSEQ_LOCKMON_EN` defined: `lock_s`=0 in STRETCH, SEQ or RUN forces WAIT_LOCK on the next edge.
  - All channels are re-asserted, `sys_rst`<=1 and `ready`<=0.
  - `lock_lost`<=1 and stays set until `trigger_reset` or `sys_rst_n`.
- Not defined: `lock_s` is examined only in WAIT_LOCK. Lock loss after leaving WAIT_LOCK is ignored and `lock_lost` is tied to 0.

## Test plan
- Power-up, N_CHAN=2, CHAN_DLY={8'd2,8'd0}, STRETCH_CYC=3: `pll_locked` rises before edge A -> `chan_rst_n`=2'b01 at edge A+7; `chan_rst_n`=2'b11, `sys_rst`=0, `ready`=1 at edge A+10.
- Async reset mid-SEQ (`sys_rst_n` low between edges) -> all outputs return to reset values immediately; after release, the full sequence repeats with identical cycle counts.
- `trigger_reset` pulsed one cycle in RUN -> next edge `chan_rst_n`=0 and `sys_rst`=1. With `pll_locked` still high, re-release follows after 1+(STRETCH_CYC+1)+sum(d_i+1) edges (no synchroniser delay).
- With `MXRSTSEQ_LOCKMON_EN`, drop `pll_locked` for 5 cycles in RUN -> resets asserted 3 edges after the drop, `lock_lost`=1. The sequence restarts when lock returns; `lock_lost` stays 1 until `trigger_reset`.
- Without the macro, same stimulus -> `chan_rst_n` stays all-ones, `ready`=1, `lock_lost`=0.
- N_CHAN=4, all delays 0, STRETCH_CYC=0: channels release on four consecutive edges 0001, 0011, 0111, 1111. `trigger_reset` together with lock loss in SEQ -> WAIT_LOCK with `lock_lost`=0.

Source files
------------

// File: rtl/mxrstseq.sv
// Multi-channel reset sequencer: waits for synchronised PLL lock, stretches reset,
// then releases channels in ascending order. Define MXRSTSEQ_LOCKMON_EN for run-time lock-loss monitoring.
module mxrstseq #(
  parameter int                          N_CHAN      = 4,
  parameter int                          DLY_W       = 8,
  parameter logic [N_CHAN*DLY_W-1:0]     CHAN_DLY    = {8'd255, 8'd128, 8'd16, 8'd0},
  parameter int                          STRETCH_W   = 20,
  parameter logic [STRETCH_W-1:0]        STRETCH_CYC = 20'hFFFFF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              pll_locked,
  input  logic              trigger_reset,
  output logic [N_CHAN-1:0] chan_rst_n,
  output logic              sys_rst,
  output logic              ready,
  output logic              lock_lost
);

  localparam int IDX_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

  typedef enum logic [1:0] {WAIT_LOCK, STRETCH, SEQ, RUN} state_e;

  state_e                 state_q, state_d;
  logic [STRETCH_W-1:0]   cnt_q, cnt_d;
  logic [DLY_W-1:0]       dly_q, dly_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [N_CHAN-1:0]      chanRstN_q, chanRstN_d;
  logic                   sysRst_q, sysRst_d;
  logic                   ready_q, ready_d;
  logic                   lockLost_q, lockLost_d;
  logic                   lockMeta_q, lockS_q;
  logic                   lockDrop;
  logic [DLY_W-1:0]       nextDly;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dly_d      = dly_q;
    idx_d      = idx_q;
    chanRstN_d = chanRstN_q;
    sysRst_d   = sysRst_q;
    ready_d    = ready_q;
    lockLost_d = lockLost_q;
    lockDrop   = 1'b0;
    nextDly    = '0;

    for (int i = 0; i < N_CHAN; i++) begin
      if (i == int'(idx_q) + 1) nextDly = CHAN_DLY[i*DLY_W +: DLY_W];
    end

`ifdef MXRSTSEQ_LOCKMON_EN
    lockDrop = (state_q != WAIT_LOCK) && !lockS_q;
`endif

    // Trigger outranks lock loss so a simultaneous drop leaves the sticky flag clear
    if (trigger_reset) begin
      chanRstN_d = '0;
      sysRst_d   = 1'b1;
      ready_d    = 1'b0;
      lockLost_d = 1'b0;
      state_d    = WAIT_LOCK;
    end else if (lockDrop) begin
      chanRstN_d = '0;
      sysRst_d   = 1'b1;
      ready_d    = 1'b0;
      lockLost_d = 1'b1;
      state_d    = WAIT_LOCK;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          chanRstN_d = '0;
          if (lockS_q) begin
            cnt_d   = STRETCH_CYC;
            state_d = STRETCH;
          end
        end
        STRETCH: begin
          if (cnt_q == '0) begin
            idx_d   = '0;
            dly_d   = CHAN_DLY[DLY_W-1:0];
            state_d = SEQ;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        SEQ: begin
          if (dly_q == '0) begin
            for (int i = 0; i < N_CHAN; i++) begin
              if (i == int'(idx_q)) chanRstN_d[i] = 1'b1;
            end
            if (int'(idx_q) == N_CHAN - 1) begin
              ready_d  = 1'b1;
              sysRst_d = 1'b0;
              state_d  = RUN;
            end else begin
              idx_d = idx_q + 1'b1;
              dly_d = nextDly;
            end
          end else begin
            dly_d = dly_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lockMeta_q <= 1'b0;
      lockS_q    <= 1'b0;
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      dly_q      <= '0;
      idx_q      <= '0;
      chanRstN_q <= '0;
      sysRst_q   <= 1'b1;
      ready_q    <= 1'b0;
      lockLost_q <= 1'b0;
    end else begin
      lockMeta_q <= pll_locked;
      lockS_q    <= lockMeta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dly_q      <= dly_d;
      idx_q      <= idx_d;
      chanRstN_q <= chanRstN_d;
      sysRst_q   <= sysRst_d;
      ready_q    <= ready_d;
      lockLost_q <= lockLost_d;
    end
  end

  assign chan_rst_n = chanRstN_q;
  assign sys_rst    = sysRst_q;
  assign ready      = ready_q;
  assign lock_lost  = lockLost_q;

endmodule

// File: tb/tb_mxrstseq.sv
// Scoreboard bench for mxrstseq: expected outputs are queued by edge number and
// compared on the falling edge; follows MXRSTSEQ_LOCKMON_EN if defined.
module tb_mxrstseq;

  localparam int N_CHAN = 4;
  localparam int SC     = 3;
  localparam int DLY_TBL [N_CHAN] = '{0, 2, 1, 0};

  // {lock_lost, ready, sys_rst, chan_rst_n}
  localparam logic [6:0] RST_VAL  = 7'b001_0000;
  localparam logic [6:0] RUN_VAL  = 7'b010_1111;
  localparam logic [6:0] LOST_VAL = 7'b101_0000;

  typedef struct {
    int         edgeNo;
    logic [6:0] val;
    string      tag;
  } expT;

  logic              clk = 1'b0;
  logic              sys_rst_n;
  logic              pll_locked;
  logic              trigger_reset;
  logic [N_CHAN-1:0] chan_rst_n;
  logic              sys_rst;
  logic              ready;
  logic              lock_lost;
  logic [6:0]        obs;

  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;
  expT expQ[$];

  mxrstseq #(
    .N_CHAN     (N_CHAN),
    .DLY_W      (8),
    .CHAN_DLY   ({8'd0, 8'd1, 8'd2, 8'd0}),
    .STRETCH_W  (4),
    .STRETCH_CYC(4'd3)
  ) dut (
    .sys_clk      (clk),
    .sys_rst_n    (sys_rst_n),
    .pll_locked   (pll_locked),
    .trigger_reset(trigger_reset),
    .chan_rst_n   (chan_rst_n),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .lock_lost    (lock_lost)
  );

  assign obs = {lock_lost, ready, sys_rst, chan_rst_n};

  always #5 clk = ~clk;

  // Edge counter: after posedge k has happened, cyc holds k
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s @edge %0d: got %0h, expected %0h", tag, cyc, observed, expected);
    end
  endtask

  // Scoreboard drain: compare every entry whose edge has been reached
  always @(negedge clk) begin
    expT e;
    while (expQ.size() > 0 && expQ[0].edgeNo <= cyc) begin
      e = expQ.pop_front();
      checkOutput(e.tag, {25'd0, obs}, {25'd0, e.val});
    end
  end

  function automatic void pushExp(input int e, input logic [6:0] v, input string tag);
    expT x;
    x.edgeNo = e;
    x.val    = v;
    x.tag    = tag;
    expQ.push_back(x);
  endfunction

  // Expected outputs for a full sequence where edge e enters STRETCH
  task automatic pushSequence(input int e, input logic ll);
    int         rel;
    logic [3:0] mask;
    mask = '0;
    rel  = e + SC + 1;
    pushExp(e, {ll, 2'b01, mask}, "stretchEntry");
    pushExp(rel, {ll, 2'b01, mask}, "seqEntry");
    for (int i = 0; i < N_CHAN; i++) begin
      rel = rel + DLY_TBL[i] + 1;
      pushExp(rel - 1, {ll, 2'b01, mask}, $sformatf("hold%0d", i));
      mask[i] = 1'b1;
      if (i == N_CHAN - 1) pushExp(rel, {ll, 2'b10, mask}, $sformatf("release%0d", i));
      else                 pushExp(rel, {ll, 2'b01, mask}, $sformatf("release%0d", i));
    end
  endtask

  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic waitUntil(input int n);
    while (cyc < n) waitEdge();
  endtask

  task automatic drainQueue(input string tag);
    for (int i = 0; i < 400 && expQ.size() != 0; i++) @(negedge clk);
    #1;
    checkOutput(tag, expQ.size(), 0);
  endtask

  task automatic applyStimulus();
    int t;
    int x;

    // Reset values
    sys_rst_n     = 1'b1;
    pll_locked    = 1'b0;
    trigger_reset = 1'b0;
    #1 sys_rst_n = 1'b0;
    #1 checkOutput("resetState", {25'd0, obs}, {25'd0, RST_VAL});

    // Power-up: lock rises before edge A, STRETCH entered at A+2
    waitEdge();
    waitEdge();
    sys_rst_n = 1'b1;
    waitEdge();
    pll_locked = 1'b1;
    pushExp(cyc + 2, RST_VAL, "waitLock");
    pushSequence(cyc + 3, 1'b0);
    drainQueue("drainPowerUp");

    // One-cycle trigger in RUN: no synchroniser delay on re-release
    waitEdge();
    pushExp(cyc + 1, RST_VAL, "trigRun");
    trigger_reset = 1'b1;
    waitEdge();
    trigger_reset = 1'b0;
    pushSequence(cyc + 1, 1'b0);
    drainQueue("drainTrigger");

    // Async reset mid-SEQ, then the identical sequence after release
    waitEdge();
    pushExp(cyc + 1, RST_VAL, "trigSeq");
    trigger_reset = 1'b1;
    waitEdge();
    trigger_reset = 1'b0;
    t = cyc;
    pushExp(t + 6, 7'b001_0001, "midSeq");
    waitUntil(t + 7);
    #2 sys_rst_n = 1'b0;
    #1 checkOutput("asyncRstImmediate", {25'd0, obs}, {25'd0, RST_VAL});
    waitEdge();
    checkOutput("asyncRstHeld", {25'd0, obs}, {25'd0, RST_VAL});
    waitEdge();
    #2 sys_rst_n = 1'b1;
    pushExp(cyc + 1, RST_VAL, "postRstWait");
    pushSequence(cyc + 3, 1'b0);
    drainQueue("drainAsyncRst");

    // Lock dropped for five cycles while in RUN
    waitEdge();
    t = cyc;
    pll_locked = 1'b0;
`ifdef MXRSTSEQ_LOCKMON_EN
    pushExp(t + 1, RUN_VAL, "dropB0");
    pushExp(t + 2, RUN_VAL, "dropB1");
    pushExp(t + 3, LOST_VAL, "dropAssert");
    pushExp(t + 4, LOST_VAL, "dropHeld");
    repeat (5) waitEdge();
    pll_locked = 1'b1;
    pushExp(cyc + 2, LOST_VAL, "relockWait");
    pushSequence(cyc + 3, 1'b1);
`else
    for (int k = 1; k <= 9; k++) pushExp(t + k, RUN_VAL, $sformatf("dropIgnored%0d", k));
    repeat (5) waitEdge();
    pll_locked = 1'b1;
`endif
    drainQueue("drainLockDrop");

    // Trigger coinciding with lock loss in SEQ, then trigger held while lock returns
    waitEdge();
    pushExp(cyc + 1, RST_VAL, "trigClearsLost");
    trigger_reset = 1'b1;
    waitEdge();
    trigger_reset = 1'b0;
    t = cyc;
    x = t + 8;
    pushExp(t + 6, 7'b001_0001, "seqCh0");
    pushExp(t + 7, 7'b001_0001, "seqHold");
    for (int k = 0; k < 4; k++) pushExp(x + k, RST_VAL, $sformatf("trigWins%0d", k));
    waitUntil(x - 3);
    pll_locked = 1'b0;
    waitUntil(x - 1);
    trigger_reset = 1'b1;
    waitUntil(x);
    pll_locked = 1'b1;
    waitUntil(x + 3);
    trigger_reset = 1'b0;
    pushSequence(x + 4, 1'b0);
    drainQueue("drainTrigLoss");
  endtask

  initial begin
    applyStimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so a stuck run still terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
